// File: rtl/i2c_slave.sv
// I2C target for one fixed 7-bit address. It oversamples scl/sda on the system clock,
// stores master writes in a byte array and serves master reads from a byte array.
module i2c_slave #(
    parameter logic [6:0] ADDRESS              = 7'b0101010,
    parameter int         MAX_BYTES_TO_RECEIVE = 2,
    parameter int         MAX_BYTES_TO_SEND    = 2,
    localparam int        CNT_W                = $clog2(MAX_BYTES_TO_RECEIVE + 1)
) (
    input  logic                                 clock_i,
    input  logic                                 reset_i,
    input  logic                                 scl_i,
    inout  wire                                  sda_io,
    input  logic [MAX_BYTES_TO_SEND-1:0][7:0]    bytes_to_send_i,
    output logic [MAX_BYTES_TO_RECEIVE-1:0][7:0] bytes_received_o,
    output logic [CNT_W-1:0]                     nr_of_bytes_received_o,
    output logic                                 write_done_o,
    output logic                                 read_done_o,
    output logic                                 busy_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
    } state_t;

    state_t state_q, state_d;
    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] idx_q, idx_d;
    logic rw_q, rw_d;
    logic sda_low_q, sda_low_d;
    logic busy_q, busy_d;
    logic write_q, write_d;
    logic wdone_q, wdone_d;
    logic rdone_q, rdone_d;
    logic [MAX_BYTES_TO_RECEIVE-1:0][7:0] rx_q, rx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0] tx_byte;

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q & scl_prev_q;
    assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
    assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

    // Past the end of the send buffer the bus sees all ones.
    always_comb begin
        tx_byte = 8'hFF;
        for (int i = 0; i < MAX_BYTES_TO_SEND; i++)
            if (idx_q == 8'(i)) tx_byte = bytes_to_send_i[i];
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        idx_d      = idx_q;
        rw_d       = rw_q;
        sda_low_d  = sda_low_q;
        busy_d     = busy_q;
        write_d    = write_q;
        rx_d       = rx_q;
        cnt_d      = cnt_q;
        wdone_d    = 1'b0;
        rdone_d    = 1'b0;
        if (stop_det) begin
            state_d   = S_IDLE;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
            wdone_d   = write_q;
            write_d   = 1'b0;
        end else if (start_det) begin
            state_d   = S_ADDR;
            sda_low_d = 1'b0;
            bit_cnt_d = 4'd0;
            wdone_d   = write_q;
            write_d   = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_sync_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        // General call (address 0) is never acknowledged.
                        if (shift_q[7:1] == ADDRESS && shift_q[7:1] != 7'd0) begin
                            state_d   = S_ADDR_ACK;
                            sda_low_d = 1'b1;
                            busy_d    = 1'b1;
                            idx_d     = 8'd0;
                            rw_d      = shift_q[0];
                            if (!shift_q[0]) begin
                                cnt_d   = '0;
                                write_d = 1'b1;
                            end
                        end else begin
                            state_d = S_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            state_d    = S_RD_BYTE;
                            tx_shift_d = {tx_byte[6:0], 1'b1};
                            sda_low_d  = ~tx_byte[7];
                        end else begin
                            state_d   = S_WR_BYTE;
                            sda_low_d = 1'b0;
                        end
                    end
                end
                S_WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_sync_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d = S_WR_ACK;
                        // No slot matches once the buffer is full, so the byte is NACKed.
                        for (int i = 0; i < MAX_BYTES_TO_RECEIVE; i++) begin
                            if (idx_q == 8'(i)) begin
                                rx_d[i]   = shift_q;
                                sda_low_d = 1'b1;
                                cnt_d     = cnt_q + CNT_W'(1);
                                idx_d     = idx_q + 8'd1;
                            end
                        end
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        state_d   = S_WR_BYTE;
                        sda_low_d = 1'b0;
                        bit_cnt_d = 4'd0;
                    end
                end
                S_RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = S_RD_ACK;
                            sda_low_d = 1'b0;
                        end else begin
                            sda_low_d  = ~tx_shift_q[7];
                            tx_shift_d = {tx_shift_q[6:0], 1'b1};
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_sync_q) begin
                            rdone_d = 1'b1;
                            state_d = S_IGNORE;
                        end else begin
                            bit_cnt_d = 4'd9;
                            if (idx_q != 8'hFF) idx_d = idx_q + 8'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        state_d    = S_RD_BYTE;
                        bit_cnt_d  = 4'd0;
                        tx_shift_d = {tx_byte[6:0], 1'b1};
                        sda_low_d  = ~tx_byte[7];
                    end
                end
                default: ;
            endcase
        end
    end

    // Synchronizers idle high so reset release never fakes a bus edge.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            tx_shift_q <= 8'd0;
            idx_q      <= 8'd0;
            rw_q       <= 1'b0;
            sda_low_q  <= 1'b0;
            busy_q     <= 1'b0;
            write_q    <= 1'b0;
            wdone_q    <= 1'b0;
            rdone_q    <= 1'b0;
            rx_q       <= '0;
            cnt_q      <= '0;
        end else begin
            scl_meta_q <= scl_i;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda_io;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            idx_q      <= idx_d;
            rw_q       <= rw_d;
            sda_low_q  <= sda_low_d;
            busy_q     <= busy_d;
            write_q    <= write_d;
            wdone_q    <= wdone_d;
            rdone_q    <= rdone_d;
            rx_q       <= rx_d;
            cnt_q      <= cnt_d;
        end
    end

    assign sda_io                 = sda_low_q ? 1'b0 : 1'bz;
    assign bytes_received_o       = rx_q;
    assign nr_of_bytes_received_o = cnt_q;
    assign write_done_o           = wdone_q;
    assign read_done_o            = rdone_q;
    assign busy_o                 = busy_q;
endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged bus master with hand-computed expectations.
module tb_i2c_slave;
    localparam int Q = 100;  // quarter SCL bit period in ns (10 system clocks)

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic sda_drv_low = 1'b0;
    wire  sda;
    logic [1:0][7:0] bts;
    logic [1:0][7:0] br;
    logic [1:0] nrx;
    logic wd, rdn, busy;

    int n_checks = 0;
    int n_fail = 0;
    int wd_cnt = 0;
    int rd_cnt = 0;
    int dut_low_cnt = 0;
    int busy_cnt = 0;

    always #5 clk = ~clk;

    assign sda = sda_drv_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave dut (
        .clock_i                (clk),
        .reset_i                (rst),
        .scl_i                  (scl),
        .sda_io                 (sda),
        .bytes_to_send_i        (bts),
        .bytes_received_o       (br),
        .nr_of_bytes_received_o (nrx),
        .write_done_o           (wd),
        .read_done_o            (rdn),
        .busy_o                 (busy)
    );

    always @(posedge clk) begin
        if (wd) wd_cnt <= wd_cnt + 1;
        if (rdn) rd_cnt <= rd_cnt + 1;
        if (sda === 1'b0 && !sda_drv_low) dut_low_cnt <= dut_low_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic i2c_start();
        #Q sda_drv_low = 1'b0;
        #Q scl = 1'b1;
        #Q sda_drv_low = 1'b1;
        #Q scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #Q sda_drv_low = 1'b1;
        #Q scl = 1'b1;
        #Q sda_drv_low = 1'b0;
        #Q;
    endtask

    task automatic send_bit(input logic b);
        #Q sda_drv_low = ~b;
        #Q scl = 1'b1;
        #Q;
        #Q scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        #Q sda_drv_low = 1'b0;
        #Q scl = 1'b1;
        #Q b = (sda === 1'b0) ? 1'b0 : 1'b1;
        #Q scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~master_ack);
    endtask

    task automatic run_write_test(input string p);
        logic ack;
        int wd0, rd0;
        wd0 = wd_cnt;
        rd0 = rd_cnt;
        i2c_start();
        write_byte(8'h54, ack);
        check_eq({p, " addr ack"}, 32'(ack), 32'd1);
        check_eq({p, " busy"}, 32'(busy), 32'd1);
        write_byte(8'h33, ack);
        check_eq({p, " data0 ack"}, 32'(ack), 32'd1);
        write_byte(8'h1C, ack);
        check_eq({p, " data1 ack"}, 32'(ack), 32'd1);
        i2c_stop();
        check_eq({p, " rx0"}, 32'(br[0]), 32'h33);
        check_eq({p, " rx1"}, 32'(br[1]), 32'h1C);
        check_eq({p, " count"}, 32'(nrx), 32'd2);
        check_eq({p, " writeDone"}, 32'(wd_cnt - wd0), 32'd1);
        check_eq({p, " readDone"}, 32'(rd_cnt - rd0), 32'd0);
        check_eq({p, " busy end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic ack;
        logic [7:0] d;
        int wd0, rd0, low0, busy0;
        bts[0] = 8'hA5;
        bts[1] = 8'h3C;

        repeat (3) @(negedge clk);
        check_eq("reset sda", 32'(sda), 32'd1);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset count", 32'(nrx), 32'd0);
        check_eq("reset rx", 32'(br), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: two-byte write
        run_write_test("t1");

        // 2: two-byte read, ACK then NACK
        wd0 = wd_cnt;
        rd0 = rd_cnt;
        i2c_start();
        write_byte(8'h55, ack);
        check_eq("t2 addr ack", 32'(ack), 32'd1);
        read_byte(1'b1, d);
        check_eq("t2 byte0", 32'(d), 32'hA5);
        read_byte(1'b0, d);
        check_eq("t2 byte1", 32'(d), 32'h3C);
        check_eq("t2 readDone", 32'(rd_cnt - rd0), 32'd1);
        check_eq("t2 sda released", 32'(sda), 32'd1);
        i2c_stop();
        check_eq("t2 writeDone", 32'(wd_cnt - wd0), 32'd0);
        check_eq("t2 busy end", 32'(busy), 32'd0);

        // 3: foreign address is ignored
        wd0 = wd_cnt;
        rd0 = rd_cnt;
        low0 = dut_low_cnt;
        busy0 = busy_cnt;
        i2c_start();
        write_byte(8'h56, ack);
        check_eq("t3 addr nack", 32'(ack), 32'd0);
        write_byte(8'h55, ack);
        check_eq("t3 data nack", 32'(ack), 32'd0);
        i2c_stop();
        check_eq("t3 sda never low", 32'(dut_low_cnt - low0), 32'd0);
        check_eq("t3 busy never", 32'(busy_cnt - busy0), 32'd0);
        check_eq("t3 pulses", 32'((wd_cnt - wd0) + (rd_cnt - rd0)), 32'd0);
        check_eq("t3 rx unchanged", 32'(br), 32'h1C33);

        // 4: overflow, third byte NACKed
        wd0 = wd_cnt;
        i2c_start();
        write_byte(8'h54, ack);
        write_byte(8'h01, ack);
        check_eq("t4 ack1", 32'(ack), 32'd1);
        write_byte(8'h02, ack);
        check_eq("t4 ack2", 32'(ack), 32'd1);
        write_byte(8'h03, ack);
        check_eq("t4 nack3", 32'(ack), 32'd0);
        i2c_stop();
        check_eq("t4 rx", 32'(br), 32'h0201);
        check_eq("t4 count", 32'(nrx), 32'd2);
        check_eq("t4 writeDone", 32'(wd_cnt - wd0), 32'd1);

        // 5: write one byte, repeated START, read one byte
        wd0 = wd_cnt;
        rd0 = rd_cnt;
        i2c_start();
        write_byte(8'h54, ack);
        write_byte(8'h77, ack);
        check_eq("t5 data ack", 32'(ack), 32'd1);
        i2c_start();
        check_eq("t5 writeDone at Sr", 32'(wd_cnt - wd0), 32'd1);
        check_eq("t5 count", 32'(nrx), 32'd1);
        check_eq("t5 rx", 32'(br), 32'h0277);
        write_byte(8'h55, ack);
        check_eq("t5 read addr ack", 32'(ack), 32'd1);
        check_eq("t5 busy", 32'(busy), 32'd1);
        read_byte(1'b0, d);
        check_eq("t5 read byte", 32'(d), 32'hA5);
        i2c_stop();
        check_eq("t5 readDone", 32'(rd_cnt - rd0), 32'd1);
        check_eq("t5 writeDone total", 32'(wd_cnt - wd0), 32'd1);

        // 6: reset while the target holds its address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h54 >> i));
        #Q sda_drv_low = 1'b0;
        #Q scl = 1'b1;
        #Q;
        check_eq("t6 ack driven", 32'(sda), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("t6 sda released in reset", 32'(sda), 32'd1);
        check_eq("t6 busy in reset", 32'(busy), 32'd0);
        #9;
        #20 rst = 1'b0;
        check_eq("t6 count cleared", 32'(nrx), 32'd0);
        #Q scl = 1'b0;
        i2c_stop();
        run_write_test("t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
